fuzz_top: RTL and testbench
===========================

FUZZ_TOP -- requirements
Module: fuzz_top

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_flat  input  261  [32i+31:32i] = operand a[i], lanes i=0..7; [258:256] = op; [259] = en; [260] = clr.
REQ-004 out_flat  output  330  [40i+39:40i] = acc[i], lanes i=0..7; [327:320] = ovf[7:0]; [328] = nz; [329] = par.

Function
REQ-005 Each lane SHALL hold a 40-bit unsigned accumulator acc[i] and a sticky overflow flag ovf[i].
REQ-006 All outputs SHALL be registered, with one-cycle latency: inputs sampled at edge N appear on out_flat after edge N.
REQ-007 Priority SHALL be: rst, then clr, then en.
REQ-008 clr=1 SHALL zero every acc and ovf, regardless of en or op.
REQ-009 en=0 (and clr=0) SHALL hold all state.
REQ-010 With en=1, each lane SHALL apply op to its own a[i] independently, all lanes in the same cycle.
REQ-011 op 0 (HOLD): acc unchanged.
REQ-012 op 1 (ADD): acc = acc + zext(a), modulo 2^40; carry-out SHALL set ovf.
REQ-013 op 2 (LOAD): acc = zext(a); ovf unchanged.
REQ-014 op 3 (SUB): acc = acc - zext(a), modulo 2^40; borrow SHALL set ovf.
REQ-015 op 4 (XOR): acc = acc ^ zext(a).
REQ-016 op 5 (ROL): acc rotated left within 40 bits by a[4:0] mod 40; amounts 40..63 SHALL NOT occur (a[4:0] is at most 31).
REQ-017 op 6 (MAX): acc = max(acc, zext(a)), unsigned compare; equal values leave acc unchanged.
REQ-018 op 7 (CNT): acc = acc + popcount(a), 0..32, modulo 2^40; carry-out SHALL set ovf.
REQ-019 ovf SHALL be sticky; only rst or clr SHALL clear it.
REQ-020 nz SHALL be 1 iff any next-state acc is nonzero, registered with acc.

Reset
REQ-021 While rst=1 at a rising edge, all acc, ovf, nz and par SHALL become 0, so out_flat = 0 after that edge.
REQ-022 Reset asserted mid-operation SHALL discard pending results; the first post-reset edge SHALL operate on zeroed state.
REQ-023 There SHALL be no asynchronous reset path.

Configuration
REQ-024 With macro FUZZ_TOP_PARITY_EN defined, par SHALL equal the XOR of next-state out_flat[328:0], registered in the same cycle.
REQ-025 Without FUZZ_TOP_PARITY_EN, out_flat[329] SHALL be constant 0 and no parity logic SHALL be built.

Structure
REQ-026 Package fuzz_top_pkg SHALL hold:
- constants N_LANES=8, A_W=32, ACC_W=40;
- the op enum (HOLD, ADD, LOAD, SUB, XOR, ROL, MAX, CNT);
- in_flat and out_flat field offsets.
REQ-027 Sub-module fuzz_top_lane SHALL implement one lane's acc/ovf state and op datapath; fuzz_top SHALL instantiate it 8 times, plus nz, parity and packing logic.

Verification
REQ-028 rst=1 for 2 edges with random in_flat -> out_flat = 0.
REQ-029 en=1, op=LOAD, all a=0xFFFFFFFF; then op=ADD 256 times with a=0xFFFFFFFF -> acc = 0x100_FFFFFFFF+... modulo 2^40 wrap check; exact values:
- after LOAD: acc = 0x00FFFFFFFF;
- after ADD of 0xFFFFFFFF: acc = 0x01FFFFFFFE, ovf = 0.
REQ-030 LOAD 0, then SUB a=1 -> acc = 0xFFFFFFFFFF, ovf = 1; later op=LOAD 5 -> acc = 5, ovf still 1; then clr=1 -> acc = 0, ovf = 0, nz = 0.
REQ-031 LOAD 0x80000001, then ROL a=8 -> acc = 0x8000000100; MAX a=0x7 -> acc unchanged; CNT a=0xF0F0F0F0 -> acc = 0x8000000110.
REQ-032 Priority check: clr=1, en=1, op=ADD, nonzero state -> all zero; en=0, op=ADD -> state held.
REQ-033 With FUZZ_TOP_PARITY_EN, 300 random cycles -> out_flat[329] = ^out_flat[328:0] every cycle; without the macro, out_flat[329] = 0 every cycle.

Source files
------------

// File: rtl/fuzz_top_pkg.sv
// Shared constants, op encoding and flat-bus field offsets for fuzz_top.
package fuzz_top_pkg;
  localparam int N_LANES = 8;
  localparam int A_W     = 32;
  localparam int ACC_W   = 40;

  localparam int IN_W        = 261;
  localparam int IN_OP_LSB   = 256;
  localparam int IN_EN_BIT   = 259;
  localparam int IN_CLR_BIT  = 260;
  localparam int OUT_W       = 330;
  localparam int OUT_OVF_LSB = 320;
  localparam int OUT_NZ_BIT  = 328;
  localparam int OUT_PAR_BIT = 329;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_ADD  = 3'd1,
    OP_LOAD = 3'd2,
    OP_SUB  = 3'd3,
    OP_XOR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_MAX  = 3'd6,
    OP_CNT  = 3'd7
  } op_e;

  function automatic logic [5:0] popcount(input logic [A_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < A_W; i++) c = c + 6'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/fuzz_top_lane.sv
// One accumulator lane: 40-bit acc plus sticky overflow, with the 8-op datapath.
// Next-state is exported so the top can derive nz/parity in the same cycle.
module fuzz_top_lane
  import fuzz_top_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  op_e              op,
  input  logic [A_W-1:0]   a,
  output logic [ACC_W-1:0] acc_q,
  output logic             ovf_q,
  output logic [ACC_W-1:0] acc_d,
  output logic             ovf_d
);
  logic [ACC_W:0]   sum_w, diff_w, cnt_w;
  logic [ACC_W-1:0] a_ext, rot_w;
  logic [4:0]       sh;

  assign a_ext  = ACC_W'(a);
  assign sh     = a[4:0];
  assign sum_w  = {1'b0, acc_q} + {1'b0, a_ext};
  assign diff_w = {1'b0, acc_q} - {1'b0, a_ext};
  assign cnt_w  = {1'b0, acc_q} + (ACC_W + 1)'(popcount(a));
  // sh never exceeds 31, so the right shift is always 9..40 (40 yields zero).
  assign rot_w  = (acc_q << sh) | (acc_q >> (ACC_W - int'(sh)));

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      case (op)
        OP_HOLD: acc_d = acc_q;
        OP_ADD:  begin acc_d = sum_w[ACC_W-1:0];  ovf_d = ovf_q | sum_w[ACC_W];  end
        OP_LOAD: acc_d = a_ext;
        OP_SUB:  begin acc_d = diff_w[ACC_W-1:0]; ovf_d = ovf_q | diff_w[ACC_W]; end
        OP_XOR:  acc_d = acc_q ^ a_ext;
        OP_ROL:  acc_d = rot_w;
        OP_MAX:  acc_d = (a_ext > acc_q) ? a_ext : acc_q;
        OP_CNT:  begin acc_d = cnt_w[ACC_W-1:0];  ovf_d = ovf_q | cnt_w[ACC_W];  end
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/fuzz_top.sv
// Eight-lane SIMD accumulator with flat in/out buses, nz flag and optional parity.
// Define FUZZ_TOP_PARITY_EN to build the parity bit; otherwise out_flat[329] is tied 0.
module fuzz_top
  import fuzz_top_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_flat,
  output logic [OUT_W-1:0] out_flat
);
  logic [N_LANES-1:0][A_W-1:0]   a;
  logic [N_LANES-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [N_LANES-1:0]            ovf_q, ovf_d;
  logic                          en, clr, nz_d, nz_q, par_q;
  op_e                           op;

  assign a   = in_flat[IN_OP_LSB-1:0];
  assign op  = op_e'(in_flat[IN_OP_LSB +: 3]);
  assign en  = in_flat[IN_EN_BIT];
  assign clr = in_flat[IN_CLR_BIT];

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    fuzz_top_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .en    (en),
      .op    (op),
      .a     (a[i]),
      .acc_q (acc_q[i]),
      .ovf_q (ovf_q[i]),
      .acc_d (acc_d[i]),
      .ovf_d (ovf_d[i])
    );
  end

  assign nz_d = |acc_d;

  always_ff @(posedge clk) begin
    if (rst) nz_q <= 1'b0;
    else     nz_q <= nz_d;
  end

`ifdef FUZZ_TOP_PARITY_EN
  logic par_d;
  assign par_d = ^{nz_d, ovf_d, acc_d};

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`else
  assign par_q = 1'b0;
`endif

  assign out_flat = {par_q, nz_q, ovf_q, acc_q};
endmodule

// File: tb/tb_fuzz_top.sv
// Randomized self-checking bench for fuzz_top against a per-lane arithmetic model.
module tb_fuzz_top;
  logic         clk = 1'b0;
  logic         rst;
  logic [260:0] in_flat;
  logic [329:0] out_flat;

  fuzz_top dut (.clk(clk), .rst(rst), .in_flat(in_flat), .out_flat(out_flat));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0]  a_v [8];
  longint       m_acc [8];
  bit           m_ovf [8];
  logic [329:0] exp_flat;

  localparam longint MOD40 = 64'h100_0000_0000;

  function automatic logic [329:0] model_out();
    logic [329:0] r;
    bit nz;
    r  = '0;
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      r[40*i +: 40] = m_acc[i][39:0];
      r[320 + i]    = m_ovf[i];
      if (m_acc[i] != 0) nz = 1;
    end
    r[328] = nz;
`ifdef FUZZ_TOP_PARITY_EN
    r[329] = ^r[328:0];
`endif
    return r;
  endfunction

  // Applies inputs at the falling edge, advances the model at the rising edge.
  task automatic step(input bit r, input bit c, input bit e, input logic [2:0] o);
    longint av, t;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < 8; i++) in_flat[32*i +: 32] = a_v[i];
    in_flat[258:256] = o;
    in_flat[259]     = e;
    in_flat[260]     = c;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      av = longint'(a_v[i]);
      if (r || c) begin
        m_acc[i] = 0; m_ovf[i] = 0;
      end else if (e) begin
        case (o)
          3'd1: begin t = m_acc[i] + av; if (t >= MOD40) m_ovf[i] = 1; m_acc[i] = t % MOD40; end
          3'd2: m_acc[i] = av;
          3'd3: begin if (av > m_acc[i]) m_ovf[i] = 1; m_acc[i] = (m_acc[i] - av + MOD40) % MOD40; end
          3'd4: m_acc[i] = m_acc[i] ^ av;
          3'd5: repeat (a_v[i] % 32) m_acc[i] = (m_acc[i] * 2) % MOD40 + m_acc[i] / (MOD40 / 2);
          3'd6: if (av > m_acc[i]) m_acc[i] = av;
          3'd7: begin t = m_acc[i] + $countones(a_v[i]); if (t >= MOD40) m_ovf[i] = 1; m_acc[i] = t % MOD40; end
          default: ;
        endcase
      end
    end
    exp_flat = model_out();
    #1;
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 8; i++) a_v[i] = v;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) a_v[i] = $urandom;
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)));
      total++;
      if (out_flat !== '0) begin
        bad++; $display("FAIL reset%0d: got %h want 0", k, out_flat);
      end
    end
  endtask

  task automatic test_add_wrap();
    set_all(32'hFFFF_FFFF);
    step(0, 0, 1, 3'd2);
    total++;
    if (out_flat[39:0] !== 40'h00FF_FFFF_FF || out_flat !== exp_flat) begin
      bad++; $display("FAIL load_ff: got %h want %h", out_flat[39:0], 40'h00FF_FFFF_FF);
    end
    step(0, 0, 1, 3'd1);
    total++;
    if (out_flat[39:0] !== 40'h01FF_FFFF_FE || out_flat[320] !== 1'b0) begin
      bad++; $display("FAIL add_first: got %h ovf %b want 01fffffffe ovf 0", out_flat[39:0], out_flat[320]);
    end
    for (int k = 0; k < 255; k++) begin
      step(0, 0, 1, 3'd1);
      total++;
      if (out_flat !== exp_flat) begin
        bad++; $display("FAIL add_wrap%0d: got %h want %h", k, out_flat[39:0], exp_flat[39:0]);
      end
    end
    total++;
    if (out_flat[327:320] !== 8'hFF) begin
      bad++; $display("FAIL add_ovf: got %h want ff", out_flat[327:320]);
    end
  endtask

  task automatic test_sub_borrow();
    step(0, 1, 0, 3'd0);
    set_all(32'd0); step(0, 0, 1, 3'd2);
    set_all(32'd1); step(0, 0, 1, 3'd3);
    total++;
    if (out_flat[39:0] !== 40'hFF_FFFF_FFFF || out_flat[320] !== 1'b1 || out_flat !== exp_flat) begin
      bad++; $display("FAIL sub_borrow: got %h ovf %b want ffffffffff ovf 1", out_flat[39:0], out_flat[320]);
    end
    set_all(32'd5); step(0, 0, 1, 3'd2);
    total++;
    if (out_flat[39:0] !== 40'd5 || out_flat[320] !== 1'b1) begin
      bad++; $display("FAIL load_sticky: got %h ovf %b want 5 ovf 1", out_flat[39:0], out_flat[320]);
    end
    step(0, 1, 0, 3'd0);
    total++;
    if (out_flat !== '0) begin
      bad++; $display("FAIL clr: got %h want 0", out_flat);
    end
  endtask

  task automatic test_rol_max_cnt();
    set_all(32'h8000_0001); step(0, 0, 1, 3'd2);
    set_all(32'd8);         step(0, 0, 1, 3'd5);
    total++;
    if (out_flat[39:0] !== 40'h80_0000_0100 || out_flat !== exp_flat) begin
      bad++; $display("FAIL rol8: got %h want 8000000100", out_flat[39:0]);
    end
    set_all(32'h7); step(0, 0, 1, 3'd6);
    total++;
    if (out_flat[39:0] !== 40'h80_0000_0100) begin
      bad++; $display("FAIL max_small: got %h want 8000000100", out_flat[39:0]);
    end
    set_all(32'hF0F0_F0F0); step(0, 0, 1, 3'd7);
    total++;
    if (out_flat[39:0] !== 40'h80_0000_0110 || out_flat !== exp_flat) begin
      bad++; $display("FAIL cnt: got %h want 8000000110", out_flat[39:0]);
    end
  endtask

  task automatic test_priority();
    logic [329:0] held;
    for (int i = 0; i < 8; i++) a_v[i] = $urandom | 32'h1;
    step(0, 0, 1, 3'd2);
    step(0, 1, 1, 3'd1);
    total++;
    if (out_flat !== '0) begin
      bad++; $display("FAIL clr_over_en: got %h want 0", out_flat);
    end
    step(0, 0, 1, 3'd2);
    held = exp_flat;
    for (int i = 0; i < 8; i++) a_v[i] = $urandom;
    step(0, 0, 0, 3'd1);
    total++;
    if (out_flat !== held) begin
      bad++; $display("FAIL en0_hold: got %h want %h", out_flat, held);
    end
  endtask

  task automatic test_random();
    bit r, c;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 8; i++) a_v[i] = $urandom;
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 29) == 0);
      step(r, c, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
      total++;
      if (out_flat !== exp_flat) begin
        bad++; $display("FAIL random%0d: got %h want %h", k, out_flat, exp_flat);
      end
      total++;
`ifdef FUZZ_TOP_PARITY_EN
      if (out_flat[329] !== ^exp_flat[328:0]) begin
`else
      if (out_flat[329] !== 1'b0) begin
`endif
        bad++; $display("FAIL par%0d: got %b want %b", k, out_flat[329], exp_flat[329]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_flat = '0;
    for (int i = 0; i < 8; i++) begin a_v[i] = '0; m_acc[i] = 0; m_ovf[i] = 0; end
    exp_flat = '0;
    test_reset();
    test_add_wrap();
    test_sub_borrow();
    test_rol_max_cnt();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
